multi_phase_light_ctrl: RTL and testbench

//  Parametrised N-phase intersection light controller with an integrated interval timer.
//  - Serves phase 0 (main road) unconditionally and skips unrequested side phases.
//  - Extends green once on demand and inserts a pedestrian WALK interval.
//  - Interval table is run-time programmable.
//  - Sits between the input synchronisers/walk register and the lamp drivers.

---
 rtl/multi_phase_light_ctrl_pkg.sv | 38 +++
 rtl/multi_phase_light_ctrl_if.sv | 33 +++
 rtl/multi_phase_light_ctrl_timer.sv | 29 ++
 rtl/multi_phase_light_ctrl.sv | 141 ++++++++++++++
 tb/tb_multi_phase_light_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_phase_light_ctrl_pkg.sv
// Shared state encoding, interval-table addresses and the next-phase search for the light controller.
// Pure definitions: no latency, no backpressure.
package multi_phase_light_ctrl_pkg;

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_EXT    = 3'd1,
    S_YELLOW = 3'd2,
    S_ALLRED = 3'd3,
    S_WALK   = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_GREEN  = 2'd0;
  localparam logic [1:0] ADDR_EXT    = 2'd1;
  localparam logic [1:0] ADDR_YELLOW = 2'd2;
  localparam logic [1:0] ADDR_WALK   = 2'd3;

  localparam int MAX_PHASES = 8;

  // First phase after cur with demand; wrapping round to phase 0 always ends the search.
  function automatic logic [2:0] next_phase(input logic [MAX_PHASES-1:0] demand,
                                            input logic [2:0] cur, input int num);
    logic [2:0] res;
    logic       found;
    int         idx;
    res   = 3'd0;
    found = 1'b0;
    for (int k = 1; k < MAX_PHASES; k++) begin
      idx = (int'(cur) + k) % num;
      if (!found && k < num && (idx == 0 || demand[idx])) begin
        res   = 3'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/multi_phase_light_ctrl_if.sv
// Controller-side bundle: timebase, demand inputs, programming port and lamp/debug outputs.
// Wiring only: no latency, no backpressure.
interface multi_phase_light_ctrl_if #(
  parameter int NUM_PHASES = 4,
  parameter int TW         = 8
);
  localparam int PW = $clog2(NUM_PHASES);

  logic                  tick;
  logic [NUM_PHASES-1:0] sensor;
  logic                  walk_req;
  logic                  prg_we;
  logic [1:0]            prg_addr;
  logic [TW-1:0]         prg_data;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic                  walk_light;
  logic                  walk_ack;
  logic [PW-1:0]         cur_phase;
  logic [2:0]            fsm_state;

  modport master (
    output tick, sensor, walk_req, prg_we, prg_addr, prg_data,
    input  green, yellow, red, walk_light, walk_ack, cur_phase, fsm_state
  );

  modport slave (
    input  tick, sensor, walk_req, prg_we, prg_addr, prg_data,
    output green, yellow, red, walk_light, walk_ack, cur_phase, fsm_state
  );

endinterface

// File: rtl/multi_phase_light_ctrl_timer.sv
// Interval down-counter: expires on the value-th tick after the load cycle; value 0 acts as 1.
// Latency: expired is combinational from the counter and tick; no backpressure.
module interval_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] value,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] cnt;

  // A tick arriving in the load cycle is deliberately dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? TW'(1) : value;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = tick & ~load & (cnt == TW'(1));

endmodule

// File: rtl/multi_phase_light_ctrl.sv
// N-phase light controller FSM with programmable interval table and pedestrian walk insertion.
// Latency: all outputs registered, one clk after the deciding tick; no backpressure (inputs always sampled).
module multi_phase_light_ctrl
  import multi_phase_light_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TW         = 8,
  parameter int T_GREEN    = 12,
  parameter int T_EXT      = 6,
  parameter int T_YELLOW   = 3,
  parameter int T_WALK     = 8,
  parameter int T_ALLRED   = 1
) (
  input  logic                    clk,
  input  logic                    sys_reset,
  multi_phase_light_ctrl_if.slave bus
);

  localparam int                    PW    = $clog2(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] LAMP0 = NUM_PHASES'(1);

  state_t                state;
  state_t                nxt_state;
  logic [PW-1:0]         nxt_phase;
  logic [PW-1:0]         phase_after;
  logic [TW-1:0]         nxt_len;
  logic [NUM_PHASES-1:0] nxt_lamp, nxt_green, nxt_yellow;
  logic                  go, expired, load, walk_pending, entering_walk;
  logic [TW-1:0]         load_val, t_green, t_ext, t_yellow, t_walk;

  interval_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (sys_reset),
    .load   (load),
    .value  (load_val),
    .tick   (bus.tick),
    .expired(expired)
  );

  assign phase_after = PW'(next_phase(MAX_PHASES'(bus.sensor), 3'(bus.cur_phase), NUM_PHASES));

  // A table write outranks any expiry in the same cycle and restarts the cycle at phase 0.
  always_comb begin
    go        = 1'b0;
    nxt_state = state;
    nxt_phase = bus.cur_phase;
    nxt_len   = t_green;
    if (bus.prg_we) begin
      go        = 1'b1;
      nxt_state = S_GREEN;
      nxt_phase = '0;
      nxt_len   = (bus.prg_addr == ADDR_GREEN) ? bus.prg_data : t_green;
    end else if (expired) begin
      go = 1'b1;
      case (state)
        S_GREEN: begin
          if (bus.sensor[bus.cur_phase]) begin
            nxt_state = S_EXT;
            nxt_len   = t_ext;
          end else begin
            nxt_state = S_YELLOW;
            nxt_len   = t_yellow;
          end
        end
        S_EXT: begin
          nxt_state = S_YELLOW;
          nxt_len   = t_yellow;
        end
        S_YELLOW: begin
          nxt_state = S_ALLRED;
          nxt_len   = TW'(T_ALLRED);
        end
        S_ALLRED: begin
          if (walk_pending) begin
            nxt_state = S_WALK;
            nxt_len   = t_walk;
          end else begin
            nxt_state = S_GREEN;
            nxt_phase = phase_after;
          end
        end
        default: begin
          nxt_state = S_GREEN;
          nxt_phase = phase_after;
        end
      endcase
    end
    nxt_lamp      = LAMP0 << nxt_phase;
    nxt_green     = (nxt_state == S_GREEN || nxt_state == S_EXT) ? nxt_lamp : '0;
    nxt_yellow    = (nxt_state == S_YELLOW) ? nxt_lamp : '0;
    entering_walk = go && (nxt_state == S_WALK);
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state          <= S_GREEN;
      load           <= 1'b1;
      load_val       <= TW'(T_GREEN);
      t_green        <= TW'(T_GREEN);
      t_ext          <= TW'(T_EXT);
      t_yellow       <= TW'(T_YELLOW);
      t_walk         <= TW'(T_WALK);
      walk_pending   <= 1'b0;
      bus.cur_phase  <= '0;
      bus.fsm_state  <= S_GREEN;
      bus.green      <= LAMP0;
      bus.yellow     <= '0;
      bus.red        <= ~LAMP0;
      bus.walk_light <= 1'b0;
      bus.walk_ack   <= 1'b0;
    end else begin
      load         <= go;
      bus.walk_ack <= entering_walk;
      if (go) begin
        state          <= nxt_state;
        load_val       <= nxt_len;
        bus.cur_phase  <= nxt_phase;
        bus.fsm_state  <= nxt_state;
        bus.green      <= nxt_green;
        bus.yellow     <= nxt_yellow;
        bus.red        <= ~(nxt_green | nxt_yellow);
        bus.walk_light <= (nxt_state == S_WALK);
      end
      if (bus.prg_we) begin
        case (bus.prg_addr)
          ADDR_GREEN:  t_green  <= bus.prg_data;
          ADDR_EXT:    t_ext    <= bus.prg_data;
          ADDR_YELLOW: t_yellow <= bus.prg_data;
          ADDR_WALK:   t_walk   <= bus.prg_data;
        endcase
      end
      // The ack cycle clears the external walk register, so a request seen then is already served.
      if (entering_walk || bus.walk_ack) begin
        walk_pending <= 1'b0;
      end else if (bus.walk_req) begin
        walk_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// Directed bench for multi_phase_light_ctrl (N=4, default intervals, one tick every 5 clk).
module tb_multi_phase_light_ctrl;
  import multi_phase_light_ctrl_pkg::*;

  logic clk;
  logic sys_reset;
  int   checks = 0;
  int   errors = 0;

  multi_phase_light_ctrl_if #(.NUM_PHASES(4), .TW(8)) bus ();

  multi_phase_light_ctrl #(
    .NUM_PHASES(4), .TW(8), .T_GREEN(12), .T_EXT(6),
    .T_YELLOW(3), .T_WALK(8), .T_ALLRED(1)
  ) dut (
    .clk      (clk),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [3:0] gy;
    logic [3:0] exp_red;
    logic [3:0] obs_red;
    @(posedge clk);
    #1;
    gy      = bus.green | bus.yellow;
    exp_red = ~gy;
    obs_red = bus.red;
    chk("lamp_onehot", 32'($countones(gy) <= 1), 32'd1);
    chk("red_decode", 32'(obs_red), 32'(exp_red));
  endtask

  task automatic tick_once();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic check_now(input string tag, input state_t st, input int ph);
    logic [3:0] lamp;
    logic [3:0] eg;
    logic [3:0] ey;
    lamp = 4'b0001 << ph;
    eg   = (st == S_GREEN || st == S_EXT) ? lamp : 4'b0000;
    ey   = (st == S_YELLOW) ? lamp : 4'b0000;
    chk({tag, "_state"},  32'(bus.fsm_state),  32'(st));
    chk({tag, "_phase"},  32'(bus.cur_phase),  32'(ph));
    chk({tag, "_green"},  32'(bus.green),      32'(eg));
    chk({tag, "_yellow"}, 32'(bus.yellow),     32'(ey));
    chk({tag, "_walk"},   32'(bus.walk_light), 32'(st == S_WALK));
    chk({tag, "_ack"},    32'(bus.walk_ack),   32'd0);
  endtask

  task automatic check_reset(input string tag);
    logic [3:0] r;
    r = bus.red;
    check_now(tag, S_GREEN, 0);
    chk({tag, "_red"}, 32'(r), 32'(4'b1110));
  endtask

  // Entered state st in this cycle: len-1 ticks hold it, the len-th leaves it.
  // Returns in the entry cycle of whatever follows.
  task automatic expect_interval(input string tag, input state_t st, input int ph, input int len);
    check_now(tag, st, ph);
    repeat (4) cyc();
    for (int i = 1; i < len; i++) begin
      tick_once();
      chk({tag, "_hold"}, 32'(bus.fsm_state), 32'(st));
    end
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  initial begin
    sys_reset    = 1'b1;
    bus.tick     = 1'b0;
    bus.sensor   = 4'b0000;
    bus.walk_req = 1'b0;
    bus.prg_we   = 1'b0;
    bus.prg_addr = 2'd0;
    bus.prg_data = 8'd0;
    cyc();
    cyc();
    check_reset("rst");
    sys_reset = 1'b0;

    // No demand: phase 0 cycles G12 / Y3 / AR1.
    expect_interval("t1_g0", S_GREEN, 0, 12);
    expect_interval("t1_y0", S_YELLOW, 0, 3);
    expect_interval("t1_ar", S_ALLRED, 0, 1);

    // Demand on phase 2 only: 1 and 3 skipped, one extension on phase 2.
    bus.sensor = 4'b0100;
    expect_interval("t2_g0", S_GREEN, 0, 12);
    expect_interval("t2_y0", S_YELLOW, 0, 3);
    expect_interval("t2_ar", S_ALLRED, 0, 1);
    expect_interval("t2_g2", S_GREEN, 2, 12);
    expect_interval("t2_ext", S_EXT, 2, 6);
    expect_interval("t2_y2", S_YELLOW, 2, 3);
    expect_interval("t2_ar2", S_ALLRED, 2, 1);

    // Walk request during G0, second request in the ack cycle is absorbed.
    bus.sensor   = 4'b0000;
    bus.walk_req = 1'b1;
    cyc();
    bus.walk_req = 1'b0;
    expect_interval("t3_g0", S_GREEN, 0, 12);
    expect_interval("t3_y0", S_YELLOW, 0, 3);
    expect_interval("t3_ar", S_ALLRED, 0, 1);
    chk("t3_ack_entry", 32'(bus.walk_ack), 32'd1);
    chk("t3_walk_entry", 32'(bus.walk_light), 32'd1);
    bus.walk_req = 1'b1;
    cyc();
    bus.walk_req = 1'b0;
    chk("t3_ack_pulse", 32'(bus.walk_ack), 32'd0);
    bus.sensor = 4'b0010;
    expect_interval("t3_walk", S_WALK, 0, 8);
    bus.sensor = 4'b0000;
    expect_interval("t3_g1", S_GREEN, 1, 12);
    expect_interval("t3_y1", S_YELLOW, 1, 3);
    expect_interval("t3_ar1", S_ALLRED, 1, 1);

    // Green reprogrammed to 5 on the expiry tick of Y2.
    bus.sensor = 4'b0100;
    expect_interval("t4_g0", S_GREEN, 0, 12);
    expect_interval("t4_y0", S_YELLOW, 0, 3);
    expect_interval("t4_ar", S_ALLRED, 0, 1);
    bus.sensor = 4'b0000;
    expect_interval("t4_g2", S_GREEN, 2, 12);
    check_now("t4_y2", S_YELLOW, 2);
    repeat (4) cyc();
    tick_once();
    tick_once();
    bus.tick     = 1'b1;
    bus.prg_we   = 1'b1;
    bus.prg_addr = ADDR_GREEN;
    bus.prg_data = 8'd5;
    cyc();
    bus.tick   = 1'b0;
    bus.prg_we = 1'b0;
    check_now("t4_restart", S_GREEN, 0);
    expect_interval("t4_g0s", S_GREEN, 0, 5);
    expect_interval("t4_y0b", S_YELLOW, 0, 3);
    expect_interval("t4_arb", S_ALLRED, 0, 1);

    // Back-to-back writes mid-G0 (yellow=0, walk=8) restart the full 5-tick green.
    repeat (4) cyc();
    tick_once();
    tick_once();
    tick_once();
    bus.prg_we   = 1'b1;
    bus.prg_addr = ADDR_YELLOW;
    bus.prg_data = 8'd0;
    cyc();
    bus.prg_addr = ADDR_WALK;
    bus.prg_data = 8'd8;
    cyc();
    bus.prg_we = 1'b0;
    expect_interval("t5_g0", S_GREEN, 0, 5);
    expect_interval("t5_y0", S_YELLOW, 0, 1);
    expect_interval("t5_ar", S_ALLRED, 0, 1);

    // Async reset in the middle of EXT on phase 2.
    bus.sensor = 4'b0100;
    expect_interval("t6_g0", S_GREEN, 0, 5);
    expect_interval("t6_y0", S_YELLOW, 0, 1);
    expect_interval("t6_ar", S_ALLRED, 0, 1);
    expect_interval("t6_g2", S_GREEN, 2, 5);
    check_now("t6_ext", S_EXT, 2);
    repeat (4) cyc();
    tick_once();
    tick_once();
    #2 sys_reset = 1'b1;
    #1 check_reset("t6_async");
    bus.sensor = 4'b0000;
    cyc();
    sys_reset = 1'b0;
    expect_interval("t6_g0r", S_GREEN, 0, 12);
    expect_interval("t6_y0r", S_YELLOW, 0, 3);
    expect_interval("t6_arr", S_ALLRED, 0, 1);
    check_now("t6_end", S_GREEN, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
